multicycle_controller: RTL

//  Moore-FSM control unit for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU op classes,
// ALU control codes (also used by the ALU) and the supported opcodes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Only ADD/SUB, SLT, OR and AND are implemented for register/immediate ALU ops.
  function automatic logic alu_funct3_legal(input logic [2:0] funct3);
    logic legal;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: maps the ALU op class plus funct fields onto
// the ALU control code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // Select ALU operation; SUB only for R-type with funct7[5] set (op5 excludes addi).
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (funct7b5 & op5) begin
              alucontrol = ALU_SUB;
            end else begin
              alucontrol = ALU_ADD;
            end
          end
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Define CTRL_BNE_EN to also accept bne (branch funct3 001) through the BEQ state.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pcwrite,
  output logic       o_adrsrc,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regwrite,
  output logic [1:0] o_resultsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_immsrc,
  output logic [2:0] o_alucontrol,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_t state_r;
  state_t next_state_s;
  state_t eff_state_s;
  state_t decode_next_s;
  logic   decode_illegal_s;
  logic   branch_taken_s;
  aluop_t aluop_s;
  logic   pcwrite_s;
  logic   memwrite_s;
  logic   irwrite_s;
  logic   regwrite_s;
  logic   illegal_s;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // While reset is held the outputs show FETCH values regardless of the stale state.
  assign eff_state_s = i_rst ? FETCH : state_r;
  assign o_state     = state_r;

  // Opcode dispatch out of DECODE; anything unsupported returns to FETCH flagged illegal.
  always_comb begin
    decode_next_s    = FETCH;
    decode_illegal_s = 1'b1;
    case (i_op)
      OP_LOAD, OP_STORE: begin
        decode_next_s    = MEMADR;
        decode_illegal_s = 1'b0;
      end
      OP_RTYPE, OP_ITYPE: begin
        if (alu_funct3_legal(i_funct3)) begin
          decode_next_s    = (i_op == OP_RTYPE) ? EXECR : EXECI;
          decode_illegal_s = 1'b0;
        end else begin
          decode_next_s    = FETCH;
          decode_illegal_s = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (i_funct3 == 3'b000) begin
          decode_next_s    = BEQ;
          decode_illegal_s = 1'b0;
`ifdef CTRL_BNE_EN
        end else if (i_funct3 == 3'b001) begin
          decode_next_s    = BEQ;
          decode_illegal_s = 1'b0;
`endif
        end else begin
          decode_next_s    = FETCH;
          decode_illegal_s = 1'b1;
        end
      end
      OP_JAL: begin
        decode_next_s    = JAL;
        decode_illegal_s = 1'b0;
      end
      default: begin
        decode_next_s    = FETCH;
        decode_illegal_s = 1'b1;
      end
    endcase
  end

  // Branch condition; bne shares the BEQ state with the zero sense inverted.
  always_comb begin
`ifdef CTRL_BNE_EN
    if (i_funct3 == 3'b001) begin
      branch_taken_s = ~i_zero;
    end else begin
      branch_taken_s = i_zero;
    end
`else
    branch_taken_s = i_zero;
`endif
  end

  // Next-state logic.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:    next_state_s = i_mem_ready ? DECODE : FETCH;
      DECODE:   next_state_s = decode_next_s;
      MEMADR:   next_state_s = (i_op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state_s = i_mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_state_s = FETCH;
      MEMWRITE: next_state_s = i_mem_ready ? FETCH : MEMWRITE;
      EXECR:    next_state_s = ALUWB;
      EXECI:    next_state_s = ALUWB;
      ALUWB:    next_state_s = FETCH;
      BEQ:      next_state_s = FETCH;
      JAL:      next_state_s = ALUWB;
      default:  next_state_s = FETCH;
    endcase
  end

  // Per-state datapath selects and raw enables.
  always_comb begin
    pcwrite_s   = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    illegal_s   = 1'b0;
    o_adrsrc    = 1'b0;
    o_resultsrc = 2'b00;
    o_alusrca   = 2'b00;
    o_alusrcb   = 2'b00;
    aluop_s     = ALUOP_ADD;
    case (eff_state_s)
      FETCH: begin
        o_alusrcb   = 2'b10;
        o_resultsrc = 2'b10;
        irwrite_s   = i_mem_ready;
        pcwrite_s   = i_mem_ready;
      end
      DECODE: begin
        o_alusrca = 2'b01;
        o_alusrcb = 2'b01;
        illegal_s = decode_illegal_s;
      end
      MEMADR: begin
        o_alusrca = 2'b10;
        o_alusrcb = 2'b01;
      end
      MEMREAD: o_adrsrc = 1'b1;
      MEMWB: begin
        o_resultsrc = 2'b01;
        regwrite_s  = 1'b1;
      end
      MEMWRITE: begin
        o_adrsrc   = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECR: begin
        o_alusrca = 2'b10;
        aluop_s   = ALUOP_FUNCT;
      end
      EXECI: begin
        o_alusrca = 2'b10;
        o_alusrcb = 2'b01;
        aluop_s   = ALUOP_FUNCT;
      end
      ALUWB: regwrite_s = 1'b1;
      BEQ: begin
        o_alusrca = 2'b10;
        aluop_s   = ALUOP_SUB;
        pcwrite_s = branch_taken_s;
      end
      JAL: begin
        o_alusrca = 2'b01;
        o_alusrcb = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: aluop_s = ALUOP_ADD;
    endcase
  end

  // Reset forces every write enable low so an abandoned instruction leaves no side effects.
  always_comb begin
    if (i_rst) begin
      o_pcwrite  = 1'b0;
      o_memwrite = 1'b0;
      o_irwrite  = 1'b0;
      o_regwrite = 1'b0;
      o_illegal  = 1'b0;
    end else begin
      o_pcwrite  = pcwrite_s;
      o_memwrite = memwrite_s;
      o_irwrite  = irwrite_s;
      o_regwrite = regwrite_s;
      o_illegal  = illegal_s;
    end
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    case (i_op)
      OP_STORE:  o_immsrc = 2'b01;
      OP_BRANCH: o_immsrc = 2'b10;
      OP_JAL:    o_immsrc = 2'b11;
      default:   o_immsrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop_s),
    .funct3     (i_funct3),
    .funct7b5   (i_funct7b5),
    .op5        (i_op[5]),
    .alucontrol (o_alucontrol)
  );

endmodule
